// File: rtl/auto_load_reader.sv
// Responder side of the auto-load handshake: owns the load address counter,
// reads one PROM word per EXECUTE pulse and writes it to the parameter registers.
module auto_load_reader #(
  parameter logic [5:0]  MAX_ADDR   = 6'd33,
  parameter logic [15:0] BLANK_WORD = 16'hFFFF,
  parameter logic [9:0]  TMO_CYCLES = 10'd1000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        AL_ENA,
  input  logic        EXECUTE,
  input  logic        INC,
  input  logic        RST_ADDR,
  input  logic        CLR_AL_DONE,
  output logic [5:0]  ADDR,
  output logic        BUSY,
  output logic        AL_DONE,
  output logic        TMO_ERR,
  output logic        MEM_RD_REQ,
  output logic [5:0]  MEM_ADDR,
  input  logic        MEM_RD_ACK,
  input  logic [15:0] MEM_DATA,
  output logic        PRM_WE,
  output logic [5:0]  PRM_ADDR,
  output logic [15:0] PRM_DATA
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, WRITE} state_t;

  state_t      state, next_state;
  logic [9:0]  tmo_cnt, tmo_cnt_nxt;
  logic        launch, ack_hit, timeout, blank, write_done, done_set;
  logic [5:0]  addr_nxt, mem_addr_nxt, prm_addr_nxt;
  logic [15:0] prm_data_nxt;
  logic        busy_nxt, req_nxt, prm_we_nxt, al_done_nxt, tmo_err_nxt;

  assign launch  = (state == IDLE) && AL_ENA && EXECUTE;
  assign ack_hit = (state == WAIT_ACK) && AL_ENA && MEM_RD_ACK;
  // The REQ cycle already counts as one request cycle, so the timeout fires
  // when the request has been high for exactly TMO_CYCLES cycles.
  assign timeout = (state == WAIT_ACK) && AL_ENA && !MEM_RD_ACK &&
                   ((tmo_cnt + 10'd1) == TMO_CYCLES);
  assign blank      = (PRM_ADDR == 6'd0) && (PRM_DATA == BLANK_WORD);
  assign write_done = (state == WRITE) && AL_ENA && (blank || (PRM_ADDR == MAX_ADDR));
  assign done_set   = timeout || write_done;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (!AL_ENA) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:     if (EXECUTE) next_state = REQ;
        REQ:      next_state = WAIT_ACK;
        WAIT_ACK: begin
          if (MEM_RD_ACK)   next_state = WRITE;
          else if (timeout) next_state = IDLE;
        end
        WRITE:    next_state = IDLE;
        default:  next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_nxt     = (next_state != IDLE);
    req_nxt      = (next_state == REQ) || (next_state == WAIT_ACK);
    prm_we_nxt   = ack_hit && !((MEM_ADDR == 6'd0) && (MEM_DATA == BLANK_WORD));
    tmo_cnt_nxt  = (next_state == WAIT_ACK) ? tmo_cnt + 10'd1 : 10'd0;
    mem_addr_nxt = launch ? ADDR : MEM_ADDR;
    prm_addr_nxt = launch ? ADDR : PRM_ADDR;
    prm_data_nxt = ack_hit ? MEM_DATA : PRM_DATA;
    al_done_nxt  = done_set ? 1'b1 : (CLR_AL_DONE ? 1'b0 : AL_DONE);
    tmo_err_nxt  = timeout  ? 1'b1 : (CLR_AL_DONE ? 1'b0 : TMO_ERR);
    addr_nxt     = RST_ADDR ? 6'd0 : (INC ? ADDR + 6'd1 : ADDR);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tmo_cnt    <= 10'd0;
      ADDR       <= 6'd0;
      BUSY       <= 1'b0;
      AL_DONE    <= 1'b0;
      TMO_ERR    <= 1'b0;
      MEM_RD_REQ <= 1'b0;
      MEM_ADDR   <= 6'd0;
      PRM_WE     <= 1'b0;
      PRM_ADDR   <= 6'd0;
      PRM_DATA   <= 16'd0;
    end else begin
      tmo_cnt    <= tmo_cnt_nxt;
      ADDR       <= addr_nxt;
      BUSY       <= busy_nxt;
      AL_DONE    <= al_done_nxt;
      TMO_ERR    <= tmo_err_nxt;
      MEM_RD_REQ <= req_nxt;
      MEM_ADDR   <= mem_addr_nxt;
      PRM_WE     <= prm_we_nxt;
      PRM_ADDR   <= prm_addr_nxt;
      PRM_DATA   <= prm_data_nxt;
    end
  end

endmodule

// File: tb/tb_auto_load_reader.sv
// Directed bench for auto_load_reader: handshake, blank abort, full load,
// timeout, enable drop, address counter and reset cases.
module tb_auto_load_reader;

  logic        CLK = 1'b0;
  logic        RST, AL_ENA, EXECUTE, INC, RST_ADDR, CLR_AL_DONE, MEM_RD_ACK;
  logic [15:0] MEM_DATA;
  logic [5:0]  ADDR, MEM_ADDR, PRM_ADDR;
  logic        BUSY, AL_DONE, TMO_ERR, MEM_RD_REQ, PRM_WE;
  logic [15:0] PRM_DATA;

  int checks = 0;
  int errors = 0;
  int weCount;
  int reqCount;
  logic weSeen;

  auto_load_reader dut (
    .CLK(CLK), .RST(RST), .AL_ENA(AL_ENA), .EXECUTE(EXECUTE), .INC(INC),
    .RST_ADDR(RST_ADDR), .CLR_AL_DONE(CLR_AL_DONE), .ADDR(ADDR), .BUSY(BUSY),
    .AL_DONE(AL_DONE), .TMO_ERR(TMO_ERR), .MEM_RD_REQ(MEM_RD_REQ),
    .MEM_ADDR(MEM_ADDR), .MEM_RD_ACK(MEM_RD_ACK), .MEM_DATA(MEM_DATA),
    .PRM_WE(PRM_WE), .PRM_ADDR(PRM_ADDR), .PRM_DATA(PRM_DATA)
  );

  always #5 CLK = ~CLK;

  // Drive one cycle of pulses, advance past the edge, then release the pulses.
  task automatic applyStimulus(input logic exec, input logic inc, input logic rstAddr,
                               input logic clr, input logic ack, input logic [15:0] data);
    EXECUTE = exec; INC = inc; RST_ADDR = rstAddr; CLR_AL_DONE = clr;
    MEM_RD_ACK = ack; MEM_DATA = data;
    @(posedge CLK); #1;
    EXECUTE = 1'b0; INC = 1'b0; RST_ADDR = 1'b0; CLR_AL_DONE = 1'b0;
    MEM_RD_ACK = 1'b0; MEM_DATA = 16'h0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    RST = 1'b1; AL_ENA = 1'b0;
    idle();
    idle();
    RST = 1'b0;
    checkOutput("rst_busy", BUSY, 0);
    checkOutput("rst_addr", ADDR, 0);
    checkOutput("rst_done", AL_DONE, 0);
    checkOutput("rst_req", MEM_RD_REQ, 0);
    checkOutput("rst_prm_data", PRM_DATA, 0);

    // EXECUTE with the window closed does nothing
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("ena_low_exec_busy", BUSY, 0);
    AL_ENA = 1'b1;

    $display("[TB] basic read, ack after 2 cycles");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("t1_busy_rise", BUSY, 1);
    checkOutput("t1_req", MEM_RD_REQ, 1);
    idle();
    idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234);
    checkOutput("t1_we", PRM_WE, 1);
    checkOutput("t1_prm_addr", PRM_ADDR, 0);
    checkOutput("t1_prm_data", PRM_DATA, 32'h1234);
    checkOutput("t1_req_drop", MEM_RD_REQ, 0);
    idle();
    checkOutput("t1_busy_fall", BUSY, 0);
    checkOutput("t1_we_once", PRM_WE, 0);
    checkOutput("t1_done", AL_DONE, 0);

    $display("[TB] blank PROM abort");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    checkOutput("t2_no_we", PRM_WE, 0);
    idle();
    checkOutput("t2_done", AL_DONE, 1);
    checkOutput("t2_tmo", TMO_ERR, 0);
    checkOutput("t2_busy", BUSY, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("t2_clr", AL_DONE, 0);

    $display("[TB] full load of 34 words");
    weCount = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 34; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      idle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1000 + 16'(i));
      if (PRM_WE) weCount++;
      checkOutput($sformatf("t3_prm_addr_%0d", i), PRM_ADDR, i);
      idle();
      checkOutput($sformatf("t3_done_%0d", i), AL_DONE, (i == 33) ? 1 : 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    end
    checkOutput("t3_we_count", weCount, 34);
    checkOutput("t3_last_data", PRM_DATA, 32'h1021);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);

    $display("[TB] read timeout");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    reqCount = MEM_RD_REQ ? 1 : 0;
    weSeen = 1'b0;
    for (int k = 0; k < 1100; k++) begin
      idle();
      if (PRM_WE) weSeen = 1'b1;
      if (!MEM_RD_REQ) break;
      reqCount++;
    end
    checkOutput("t4_req_cycles", reqCount, 1000);
    checkOutput("t4_done", AL_DONE, 1);
    checkOutput("t4_tmo", TMO_ERR, 1);
    checkOutput("t4_busy", BUSY, 0);
    checkOutput("t4_no_we", weSeen, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("t4_clr_tmo", TMO_ERR, 0);

    $display("[TB] enable dropped while waiting for ack");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    idle();
    AL_ENA = 1'b0;
    idle();
    checkOutput("t5_busy", BUSY, 0);
    checkOutput("t5_req", MEM_RD_REQ, 0);
    AL_ENA = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4321);
    checkOutput("t5_late_ack_we", PRM_WE, 0);
    idle();
    checkOutput("t5_late_ack_we2", PRM_WE, 0);
    checkOutput("t5_done", AL_DONE, 0);

    $display("[TB] address counter and busy cases");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int j = 0; j < 63; j++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("t6_addr63", ADDR, 63);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("t6_wrap", ADDR, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    checkOutput("t6_rst_prio", ADDR, 0);
    for (int j = 0; j < 3; j++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("t6_mem_addr", MEM_ADDR, 3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("t6_inc_busy", ADDR, 4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5555);
    checkOutput("t6_prm_addr", PRM_ADDR, 3);
    idle();
    checkOutput("t6_busy_fall", BUSY, 0);
    idle();
    checkOutput("t6_no_queue", BUSY, 0);
    checkOutput("t6_mem_addr_hold", MEM_ADDR, 3);

    // Reset lands while the write strobe is up
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7777);
    checkOutput("t6_pre_rst_we", PRM_WE, 1);
    RST = 1'b1;
    idle();
    RST = 1'b0;
    checkOutput("t6_rst_we", PRM_WE, 0);
    checkOutput("t6_rst_busy", BUSY, 0);
    checkOutput("t6_rst_addr", ADDR, 0);
    checkOutput("t6_rst_mem_addr", MEM_ADDR, 0);
    checkOutput("t6_rst_prm_data", PRM_DATA, 0);
    checkOutput("t6_rst_prm_addr", PRM_ADDR, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
